// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//   Shares one multi-cycle, variable-latency multiplier between NUM_REQ
//   requesters. A round-robin arbiter accepts one operation at a time. The
//   accepted operands are latched onto m_a/m_b, and a single-cycle m_valid
//   start pulse is issued. The arbiter then waits for m_done and returns the
//   product to the granted requester as a one-cycle rsp_valid strobe. If the
//   multiplier never answers, a watchdog aborts the operation and reports
//   rsp_err with a zero result.
//
//   Parameters
//     DATA_WIDTH  operand width; the product is 2*DATA_WIDTH
//     NUM_REQ     number of requesters (>= 2)
//     TIMEOUT     maximum WAIT cycles before abort; 0 disables the watchdog
//
//   Ports
//     clk, rst_n      clock; asynchronous active-low reset
//     req_valid       per-requester request, held until req_ready
//     req_a, req_b    packed operands, slice i belongs to requester i
//     req_ready       one-hot accept strobe (IDLE only)
//     rsp_valid       one-hot one-cycle result strobe to the granted requester
//     rsp_c, rsp_err  result data / watchdog abort flag, qualified by rsp_valid
//     m_a, m_b        operands to the multiplier, stable from ISSUE through WAIT
//     m_valid         single-cycle start pulse to the multiplier
//     m_done, m_c     completion strobe and product from the multiplier
//     busy            high in every state except IDLE
// -----------------------------------------------------------------------------
module mult_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [2*DATA_WIDTH-1:0]       rsp_c,
    output logic                          rsp_err,
    output logic [DATA_WIDTH-1:0]         m_a,
    output logic [DATA_WIDTH-1:0]         m_b,
    output logic                          m_valid,
    input  logic                          m_done,
    input  logic [2*DATA_WIDTH-1:0]       m_c,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // The watchdog only ever holds 0..TIMEOUT-1; abort fires on the cycle it
    // would have reached TIMEOUT.
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W:0]   NREQ     = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam bit               WD_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [DATA_WIDTH-1:0]   m_a_q, m_a_d;
    logic [DATA_WIDTH-1:0]   m_b_q, m_b_d;
    logic [2*DATA_WIDTH-1:0] rsp_c_q, rsp_c_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [WD_W-1:0]         wd_q, wd_d;

    logic [DATA_WIDTH-1:0]   a_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]   b_arr [NUM_REQ];
    logic                    found;
    logic [IDX_W-1:0]        winner;
    logic [IDX_W:0]          cand;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = req_a[i*DATA_WIDTH +: DATA_WIDTH];
            b_arr[i] = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search starting at rr_ptr; the candidate index wraps modulo
    // NUM_REQ without a divider so non-power-of-two NUM_REQ works too.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req_valid[cand[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        m_a_d     = m_a_q;
        m_b_d     = m_b_q;
        rsp_c_d   = rsp_c_q;
        rsp_err_d = rsp_err_q;
        wd_d      = wd_q;
        req_ready = '0;
        rsp_valid = '0;
        m_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                // rst_n gating keeps req_ready low while reset is held.
                if (found && rst_n) begin
                    req_ready[winner] = 1'b1;
                    m_a_d             = a_arr[winner];
                    m_b_d             = b_arr[winner];
                    grant_d           = winner;
                    state_d           = ISSUE;
                end
            end
            ISSUE: begin
                m_valid = 1'b1;
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A completion arriving on the timeout cycle still wins.
                if (m_done) begin
                    rsp_c_d   = m_c;
                    rsp_err_d = 1'b0;
                    state_d   = RESP;
                end else if (WD_EN && (wd_q == WD_LAST)) begin
                    rsp_c_d   = '0;
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RESP: begin
                rsp_valid[grant_q] = 1'b1;
                rr_ptr_d           = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            m_a_q     <= '0;
            m_b_q     <= '0;
            rsp_c_q   <= '0;
            rsp_err_q <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            m_a_q     <= m_a_d;
            m_b_q     <= m_b_d;
            rsp_c_q   <= rsp_c_d;
            rsp_err_q <= rsp_err_d;
            wd_q      <= wd_d;
        end
    end

    assign m_a     = m_a_q;
    assign m_b     = m_b_q;
    assign rsp_c   = rsp_c_q;
    assign rsp_err = rsp_err_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
//   Directed bench for mult_arbiter (DATA_WIDTH=32, NUM_REQ=4, TIMEOUT=256)
//   with a multiplier stub of programmable latency. A latency of 0 means the
//   stub never answers. extra_done lets the bench inject a stray m_done.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [31:0]  ta  [4];
    logic [31:0]  tbv [4];
    logic [127:0] req_a, req_b;
    logic [3:0]   req_ready, rsp_valid;
    logic [63:0]  rsp_c;
    logic         rsp_err;
    logic [31:0]  m_a, m_b;
    logic         m_valid, m_done;
    logic [63:0]  m_c;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    assign req_a = {ta[3], ta[2], ta[1], ta[0]};
    assign req_b = {tbv[3], tbv[2], tbv[1], tbv[0]};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .TIMEOUT(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_c     (rsp_c),
        .rsp_err   (rsp_err),
        .m_a       (m_a),
        .m_b       (m_b),
        .m_valid   (m_valid),
        .m_done    (m_done),
        .m_c       (m_c),
        .busy      (busy)
    );

    // Multiplier stub: done is seen by the arbiter L cycles after it sampled m_valid.
    int          stub_lat = 1;
    logic        extra_done = 1'b0;
    logic [15:0] st_cnt;
    logic [31:0] st_a, st_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_cnt <= '0;
            st_a   <= '0;
            st_b   <= '0;
        end else if (m_valid) begin
            st_cnt <= 16'(stub_lat);
            st_a   <= m_a;
            st_b   <= m_b;
        end else if (st_cnt != 16'd0) begin
            st_cnt <= st_cnt - 16'd1;
        end
    end

    assign m_done = (st_cnt == 16'd1) | extra_done;
    assign m_c    = extra_done ? 64'hDEAD_BEEF_DEAD_BEEF : ({32'b0, st_a} * {32'b0, st_b});

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(input int limit, output int at);
        at = -1;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (rsp_valid != 4'd0) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("rsp_seen", 64'(|rsp_valid), 64'(1));
    endtask

    // Issues one request from requester r and returns the accept-to-rsp_valid
    // latency in cycles; leaves the bench at the negedge of the RESP cycle.
    task automatic run_op(input logic [1:0] r, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int limit, output int lat_obs);
        int         hs;
        int         n;
        logic [3:0] oh;
        oh       = 4'b0001 << r;
        stub_lat = lat;
        @(negedge clk);
        ta[r]        = a;
        tbv[r]       = b;
        req_valid[r] = 1'b1;
        #1;
        check("req_ready", 64'(req_ready), 64'(oh));
        hs = cyc;
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
        @(negedge clk);
        check("m_valid", 64'(m_valid), 64'(1));
        check("m_a", 64'(m_a), 64'(a));
        check("m_b", 64'(m_b), 64'(b));
        wait_rsp(limit, n);
        lat_obs = n - hs;
        check("rsp_route", 64'(rsp_valid), 64'(oh));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int         lat;
        int         n;
        int         hs;
        int         ng;
        int         last_g;
        logic [1:0] g;
        logic       seen;
        int         exp_order [8];
        exp_order = '{0, 1, 2, 3, 0, 1, 0, 1};

        for (int i = 0; i < 4; i++) begin
            ta[i]  = '0;
            tbv[i] = '0;
        end
        req_valid = '0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_c", rsp_c, 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_m_a", 64'(m_a), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic product and latency (L=3 -> 5 cycles accept to response)
        run_op(2'd0, 32'd342, 32'd25, 3, 20, lat);
        check("t1_latency", 64'(lat), 64'(5));
        check("t1_rsp_c", rsp_c, 64'd8550);
        check("t1_rsp_err", 64'(rsp_err), 64'(0));
        @(negedge clk);
        check("t1_rsp_pulse", 64'(rsp_valid), 64'(0));
        check("t1_rsp_c_hold", rsp_c, 64'd8550);
        check("t1_idle", 64'(busy), 64'(0));

        // Zero operands
        run_op(2'd1, 32'd0, 32'd1, 2, 20, lat);
        check("t2a_rsp_c", rsp_c, 64'd0);
        check("t2a_err", 64'(rsp_err), 64'(0));
        run_op(2'd2, 32'd1, 32'd0, 2, 20, lat);
        check("t2b_rsp_c", rsp_c, 64'd0);
        check("t2b_err", 64'(rsp_err), 64'(0));

        // Round robin: all requesting from reset, 0 and 1 keep requesting
        stub_lat = 1;
        for (int i = 0; i < 4; i++) begin
            ta[i]  = 32'(i + 2);
            tbv[i] = 32'd10;
        end
        @(negedge clk);
        req_valid = 4'hF;
        rst_n     = 1'b0;
        #1;
        check("t3_rst_ready", 64'(req_ready), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        ng     = 0;
        last_g = 0;
        g      = 2'd0;
        for (int c = 0; c < 300 && ng < 8; c++) begin
            if (req_ready != 4'd0) begin
                for (int i = 0; i < 4; i++) if (req_ready[i]) g = 2'(i);
                check($sformatf("t3_grant%0d", ng), 64'(g), 64'(exp_order[ng]));
                last_g = int'(g);
                ng++;
                @(posedge clk);
                #1;
                if (ng == 8) req_valid = '0;
                else if (g >= 2'd2) req_valid[g] = 1'b0;
            end else if (rsp_valid != 4'd0) begin
                check("t3_rsp_route", 64'(rsp_valid), 64'(4'b0001 << last_g));
                check("t3_rsp_c", rsp_c, 64'((last_g + 2) * 10));
            end
            @(negedge clk);
        end
        check("t3_grant_count", 64'(ng), 64'(8));
        wait_rsp(20, n);
        check("t3_last_route", 64'(rsp_valid), 64'(4'b0010));
        check("t3_last_c", rsp_c, 64'd30);

        // Watchdog: stub never answers
        run_op(2'd2, 32'd5, 32'd6, 0, 400, lat);
        check("t4_latency", 64'(lat), 64'(258));
        check("t4_err", 64'(rsp_err), 64'(1));
        check("t4_rsp_c", rsp_c, 64'd0);
        run_op(2'd3, 32'd3, 32'd4, 2, 20, lat);
        check("t4_next_latency", 64'(lat), 64'(4));
        check("t4_next_c", rsp_c, 64'd12);
        check("t4_next_err", 64'(rsp_err), 64'(0));

        // Stray m_done in IDLE and in ISSUE
        stub_lat = 2;
        @(negedge clk);
        extra_done = 1'b1;
        @(negedge clk);
        extra_done = 1'b0;
        #1;
        check("t5_idle_busy", 64'(busy), 64'(0));
        check("t5_idle_rsp", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        ta[0]        = 32'd9;
        tbv[0]       = 32'd9;
        req_valid[0] = 1'b1;
        #1;
        hs = cyc;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        extra_done   = 1'b1;
        @(posedge clk);
        #1;
        extra_done = 1'b0;
        wait_rsp(20, n);
        check("t5_issue_latency", 64'(n - hs), 64'(4));
        check("t5_issue_c", rsp_c, 64'd81);
        check("t5_issue_err", 64'(rsp_err), 64'(0));
        check("t5_issue_route", 64'(rsp_valid), 64'(4'b0001));

        // Done on the timeout cycle wins
        run_op(2'd1, 32'd100, 32'd200, 256, 400, lat);
        check("t5_tie_latency", 64'(lat), 64'(258));
        check("t5_tie_err", 64'(rsp_err), 64'(0));
        check("t5_tie_c", rsp_c, 64'd20000);

        // Reset during WAIT
        stub_lat = 0;
        @(negedge clk);
        ta[0]        = 32'd1;
        tbv[0]       = 32'd1;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_pre_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("t6_busy", 64'(busy), 64'(0));
        check("t6_m_a", 64'(m_a), 64'(0));
        check("t6_m_valid", 64'(m_valid), 64'(0));
        check("t6_rsp_c", rsp_c, 64'd0);
        check("t6_rsp_err", 64'(rsp_err), 64'(0));
        check("t6_rsp_valid", 64'(rsp_valid), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid != 4'd0 || busy) seen = 1'b1;
        end
        check("t6_quiet", 64'(seen), 64'(0));
        run_op(2'd3, 32'd7, 32'd6, 3, 20, lat);
        check("t6_c", rsp_c, 64'd42);
        check("t6_latency", 64'(lat), 64'(5));
        check("t6_err", 64'(rsp_err), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
